// File: rtl/addernet_pkg.sv
// Shared definitions for the AdderNet array controller.
//   - Default X/W and psum element widths.
//   - Controller FSM state encodings (IDLE/LOAD_W/STREAM/DRAIN/DONE).
//   - pipe_depth(): depth of the in-flight valid pipe (rows of skew plus columns of psum travel).
package addernet_pkg;

  localparam int unsigned BitWidthXwDef   = 8;
  localparam int unsigned BitWidthPsumDef = 16;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StLoadW  = 3'd1;
  localparam logic [2:0] StStream = 3'd2;
  localparam logic [2:0] StDrain  = 3'd3;
  localparam logic [2:0] StDone   = 3'd4;

  function automatic int unsigned pipe_depth(input int unsigned rows, input int unsigned cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/addernet_skew_buf.sv
// Triangular delay line for the array's left edge: row r of the input vector is delayed by
// r register stages, so row 0 passes straight through.
// Ports:
//   clk   clock
//   clr   synchronous active-high clear of all stages
//   din   ROWS*WIDTH input vector, row r at bits [r*WIDTH +: WIDTH]
//   dout  ROWS*WIDTH skewed output vector
module addernet_skew_buf #(
  parameter int unsigned ROWS  = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [ROWS*WIDTH-1:0] din,
  output logic [ROWS*WIDTH-1:0] dout
);

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    if (r == 0) begin : g_pass
      assign dout[0 +: WIDTH] = din[0 +: WIDTH];
    end else begin : g_dly
      logic [WIDTH-1:0] stage_q [r];

      always_ff @(posedge clk) begin
        if (clr) begin
          for (int i = 0; i < r; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= din[r*WIDTH +: WIDTH];
          for (int i = 1; i < r; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign dout[r*WIDTH +: WIDTH] = stage_q[r-1];
    end
  end

endmodule

// File: rtl/addernet_array_ctrl.sv
// Sequencer for a weight-stationary ROWS x COLS AdderNet PE array.
// Loads weights row by row, streams X vectors into the left edge with per-row skew, feeds zero
// psum into the top edge and flags each column's bottom psum as valid.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   i_start, i_num_vec        begin a pass (IDLE only) with the given vector count
//   i_w_valid/o_w_ready       weight-row handshake; i_w_row, i_w_negzero carry the row
//   o_StoreW, o_W, o_NegZeroW one-hot row store enable, broadcast weights, per-PE bypass flags
//   i_x_valid/o_x_ready       X vector handshake; i_x_vec carries the vector
//   o_X, o_PSUM               skewed left-edge X, top-edge psum (always zero)
//   o_psum_valid              per-column bottom psum valid
//   o_busy, o_done            pass in progress, end-of-pass pulse
// Optional (macro ADDERNET_CTRL_PERF_EN): o_perf_bubbles, o_perf_cycles saturating counters.
module addernet_array_ctrl
  import addernet_pkg::*;
#(
  parameter int unsigned ROWS           = 4,
  parameter int unsigned COLS           = 4,
  parameter int unsigned BIT_WIDTH_XW   = BitWidthXwDef,
  parameter int unsigned BIT_WIDTH_PSUM = BitWidthPsumDef,
  parameter int unsigned CNT_W          = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_start,
  input  logic [CNT_W-1:0]               i_num_vec,
  input  logic                           i_w_valid,
  output logic                           o_w_ready,
  input  logic [COLS*BIT_WIDTH_XW-1:0]   i_w_row,
  input  logic [COLS-1:0]                i_w_negzero,
  output logic [ROWS-1:0]                o_StoreW,
  output logic [COLS*BIT_WIDTH_XW-1:0]   o_W,
  output logic [ROWS*COLS-1:0]           o_NegZeroW,
  input  logic                           i_x_valid,
  output logic                           o_x_ready,
  input  logic [ROWS*BIT_WIDTH_XW-1:0]   i_x_vec,
  output logic [ROWS*BIT_WIDTH_XW-1:0]   o_X,
  output logic [COLS*BIT_WIDTH_PSUM-1:0] o_PSUM,
  output logic [COLS-1:0]                o_psum_valid,
  output logic                           o_busy,
  output logic                           o_done
`ifdef ADDERNET_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]               o_perf_bubbles,
  output logic [CNT_W-1:0]               o_perf_cycles
`endif
);

  localparam int unsigned Depth = pipe_depth(ROWS, COLS);
  localparam int unsigned RowW  = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [2:0]                    state_q, state_d;
  logic [RowW-1:0]               row_q;
  logic [CNT_W-1:0]              cnt_q;
  logic [ROWS-1:0]               storew_q;
  logic [COLS*BIT_WIDTH_XW-1:0]  w_q;
  logic [ROWS*COLS-1:0]          negzero_q;
  logic [ROWS*BIT_WIDTH_XW-1:0]  x_q;
  logic [Depth-1:0]              vld_q;
  logic                          w_acc, x_acc, last_row, start_acc;

  assign o_w_ready = (state_q == StLoadW);
  assign o_x_ready = (state_q == StStream);
  assign w_acc     = i_w_valid & o_w_ready;
  assign x_acc     = i_x_valid & o_x_ready;
  assign last_row  = (row_q == RowW'(ROWS - 1));
  assign start_acc = (state_q == StIdle) & i_start;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (i_start) state_d = StLoadW;
      StLoadW:  if (w_acc && last_row) state_d = (cnt_q == '0) ? StDone : StStream;
      StStream: if (x_acc && cnt_q == CNT_W'(1)) state_d = StDrain;
      // Pipe empty means the last column's final valid pulse has already left.
      StDrain:  if (vld_q == '0) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      row_q     <= '0;
      cnt_q     <= '0;
      storew_q  <= '0;
      w_q       <= '0;
      negzero_q <= '0;
      x_q       <= '0;
      vld_q     <= '0;
    end else begin
      state_q  <= state_d;
      storew_q <= w_acc ? (ROWS'(1) << row_q) : '0;
      if (start_acc) begin
        row_q <= '0;
        cnt_q <= i_num_vec;
      end
      if (w_acc) begin
        row_q                           <= row_q + RowW'(1);
        w_q                             <= i_w_row;
        negzero_q[row_q*COLS +: COLS]   <= i_w_negzero;
      end
      if (x_acc) cnt_q <= cnt_q - CNT_W'(1);
      // The array never stalls: a cycle without a vector becomes a zero bubble.
      x_q   <= x_acc ? i_x_vec : '0;
      vld_q <= {vld_q[Depth-2:0], x_acc};
    end
  end

  addernet_skew_buf #(
    .ROWS  (ROWS),
    .WIDTH (BIT_WIDTH_XW)
  ) u_skew (
    .clk  (clk),
    .clr  (rst),
    .din  (x_q),
    .dout (o_X)
  );

  assign o_StoreW     = storew_q;
  assign o_W          = w_q;
  assign o_NegZeroW   = negzero_q;
  assign o_PSUM       = '0;
  assign o_psum_valid = vld_q[Depth-1:ROWS];
  assign o_busy       = (state_q != StIdle);
  assign o_done       = (state_q == StDone);

`ifdef ADDERNET_CTRL_PERF_EN
  logic [CNT_W-1:0] bub_q, cyc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bub_q <= '0;
      cyc_q <= '0;
    end else if (start_acc) begin
      bub_q <= '0;
      cyc_q <= '0;
    end else begin
      if (state_q == StStream && !x_acc && bub_q != '1) bub_q <= bub_q + CNT_W'(1);
      if (o_busy && cyc_q != '1) cyc_q <= cyc_q + CNT_W'(1);
    end
  end

  assign o_perf_bubbles = bub_q;
  assign o_perf_cycles  = cyc_q;
`endif

endmodule

// File: tb/tb_addernet_array_ctrl.sv
// Self-checking bench for addernet_array_ctrl: expected X/valid/done events are queued with
// their cycle stamps when stimulus is driven and matched as the DUT produces them.
module tb_addernet_array_ctrl;

  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int XW   = 8;
  localparam int PW   = 16;
  localparam int CW   = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                i_start;
  logic [CW-1:0]       i_num_vec;
  logic                i_w_valid;
  logic                o_w_ready;
  logic [COLS*XW-1:0]  i_w_row;
  logic [COLS-1:0]     i_w_negzero;
  logic [ROWS-1:0]     o_StoreW;
  logic [COLS*XW-1:0]  o_W;
  logic [ROWS*COLS-1:0] o_NegZeroW;
  logic                i_x_valid;
  logic                o_x_ready;
  logic [ROWS*XW-1:0]  i_x_vec;
  logic [ROWS*XW-1:0]  o_X;
  logic [COLS*PW-1:0]  o_PSUM;
  logic [COLS-1:0]     o_psum_valid;
  logic                o_busy;
  logic                o_done;
`ifdef ADDERNET_CTRL_PERF_EN
  logic [CW-1:0]       perf_bub, perf_cyc;
`endif

  addernet_array_ctrl #(
    .ROWS (ROWS), .COLS (COLS), .BIT_WIDTH_XW (XW), .BIT_WIDTH_PSUM (PW), .CNT_W (CW)
  ) dut (
    .clk (clk), .rst (rst), .i_start (i_start), .i_num_vec (i_num_vec),
    .i_w_valid (i_w_valid), .o_w_ready (o_w_ready), .i_w_row (i_w_row),
    .i_w_negzero (i_w_negzero), .o_StoreW (o_StoreW), .o_W (o_W), .o_NegZeroW (o_NegZeroW),
    .i_x_valid (i_x_valid), .o_x_ready (o_x_ready), .i_x_vec (i_x_vec), .o_X (o_X),
    .o_PSUM (o_PSUM), .o_psum_valid (o_psum_valid), .o_busy (o_busy), .o_done (o_done)
`ifdef ADDERNET_CTRL_PERF_EN
    , .o_perf_bubbles (perf_bub), .o_perf_cycles (perf_cyc)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    logic [XW-1:0] val;
  } xexp_t;

  xexp_t q_x[ROWS][$];
  int    q_pv[COLS][$];
  int    q_done[$];

  logic [XW-1:0]   w_val [ROWS];
  logic [COLS-1:0] w_nz  [ROWS];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic flush_sb();
    for (int r = 0; r < ROWS; r++) q_x[r].delete();
    for (int c = 0; c < COLS; c++) q_pv[c].delete();
    q_done.delete();
  endtask

  // Output monitor: every valid/done pulse must match a queued expectation for this cycle.
  always @(negedge clk) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) begin
        if (q_x[r].size() > 0 && q_x[r][0].cyc == cyc) begin
          xexp_t e;
          e = q_x[r].pop_front();
          check_eq($sformatf("x_row%0d", r), 64'(o_X[r*XW +: XW]), 64'(e.val));
        end
      end
      for (int c = 0; c < COLS; c++) begin
        if (q_pv[c].size() > 0 && q_pv[c][0] < cyc) begin
          void'(q_pv[c].pop_front());
          check_eq($sformatf("pv%0d_missing", c), 0, 1);
        end
        if (o_psum_valid[c]) begin
          if (q_pv[c].size() == 0) check_eq($sformatf("pv%0d_spurious", c), 1, 0);
          else check_eq($sformatf("pv%0d_cyc", c), 64'(cyc), 64'(q_pv[c].pop_front()));
        end
      end
      if (q_done.size() > 0 && q_done[0] < cyc) begin
        void'(q_done.pop_front());
        check_eq("done_missing", 0, 1);
      end
      if (o_done) begin
        if (q_done.size() == 0) check_eq("done_spurious", 1, 0);
        else check_eq("done_cyc", 64'(cyc), 64'(q_done.pop_front()));
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, "_storew"}, 64'(o_StoreW), 0);
    check_eq({tag, "_w"}, 64'(o_W), 0);
    check_eq({tag, "_nz"}, 64'(o_NegZeroW), 0);
    check_eq({tag, "_x"}, 64'(o_X), 0);
    check_eq({tag, "_pv_busy_done"}, 64'({o_psum_valid, o_busy, o_done}), 0);
    check_eq({tag, "_ready"}, 64'({o_w_ready, o_x_ready}), 0);
  endtask

  // Four weight beats back to back; ends at the negedge of the first cycle after loading.
  task automatic load_weights();
    logic [ROWS*COLS-1:0] exp_nz;
    for (int r = 0; r < ROWS; r++) begin
      i_w_valid   = 1'b1;
      i_w_row     = {COLS{w_val[r]}};
      i_w_negzero = w_nz[r];
      @(negedge clk);
      check_eq("w_ready", 64'(o_w_ready), 1);
      if (r > 0) begin
        check_eq("storew", 64'(o_StoreW), 64'(1) << (r - 1));
        check_eq("w_bcast", 64'(o_W), 64'({COLS{w_val[r-1]}}));
      end
      tick();
    end
    i_w_valid = 1'b0;
    @(negedge clk);
    check_eq("storew_last", 64'(o_StoreW), 64'(1) << (ROWS - 1));
    for (int r = 0; r < ROWS; r++) exp_nz[r*COLS +: COLS] = w_nz[r];
    check_eq("negzero", 64'(o_NegZeroW), 64'(exp_nz));
    check_eq("negzero_row1", 64'(o_NegZeroW[7:4]), 64'(4'b0101));
  endtask

  task automatic drive_vector(input logic [ROWS*XW-1:0] v, input bit valid);
    i_x_valid = valid;
    i_x_vec   = v;
    check_eq("x_ready", 64'(o_x_ready), 1);
    for (int r = 0; r < ROWS; r++) begin
      xexp_t e;
      e.cyc = cyc + 1 + r;
      e.val = valid ? v[r*XW +: XW] : '0;
      q_x[r].push_back(e);
    end
    if (valid) for (int c = 0; c < COLS; c++) q_pv[c].push_back(cyc + 1 + ROWS + c);
  endtask

  task automatic start_pass(input int n);
    i_start   = 1'b1;
    i_num_vec = CW'(n);
    if (n == 0) q_done.push_back(cyc + ROWS + 1);
    tick();
    i_start = 1'b0;
    check_eq("busy_after_start", 64'(o_busy), 1);
  endtask

  task automatic run_pass(input int n, input logic [31:0] gap_mask, input bit extra_start);
    int vi = 0;
    int bub = 0;
    int t_last = 0;
    int guard = 0;
    bit bubbled = 1'b0;
    start_pass(n);
    load_weights();
    while (vi < n) begin
      if (extra_start && vi == 0 && !bubbled) begin
        i_start   = 1'b1;
        i_num_vec = CW'(9);
      end
      if (gap_mask[vi] && !bubbled) begin
        drive_vector('0, 1'b0);
        bubbled = 1'b1;
        bub++;
      end else begin
        drive_vector(ROWS*XW'($urandom), 1'b1);
        t_last  = cyc;
        bubbled = 1'b0;
        vi++;
      end
      tick();
      i_start = 1'b0;
      check_eq("storew_idle", 64'(o_StoreW), 0);
    end
    i_x_valid = 1'b0;
    i_x_vec   = '0;
    if (n > 0) begin
      q_done.push_back(t_last + ROWS + COLS + 2);
      check_eq("x_ready_drain", 64'(o_x_ready), 0);
    end
    while (q_done.size() != 0 && guard < 200) begin
      tick();
      guard++;
    end
    if (guard >= 200) begin
      check_eq("done_timeout", 0, 1);
      flush_sb();
    end
    tick();
    check_eq("idle_after_pass", 64'({o_busy, o_done}), 0);
    check_eq("negzero_held", 64'(o_NegZeroW[7:4]), 64'(4'b0101));
    check_eq("psum_zero", 64'(o_PSUM), 0);
`ifdef ADDERNET_CTRL_PERF_EN
    if (n > 0) begin
      check_eq("perf_bubbles", 64'(perf_bub), 64'(bub));
      check_eq("perf_cycles", 64'(perf_cyc), 64'(ROWS + n + bub + ROWS + COLS + 2));
    end
`endif
  endtask

  initial begin
    w_val[0] = 8'h11; w_val[1] = 8'h22; w_val[2] = 8'h33; w_val[3] = 8'h44;
    w_nz[0]  = 4'b0011; w_nz[1] = 4'b0101; w_nz[2] = 4'b1000; w_nz[3] = 4'b1110;
    rst = 1'b1; i_start = 1'b0; i_num_vec = '0; i_w_valid = 1'b0; i_w_row = '0;
    i_w_negzero = '0; i_x_valid = 1'b0; i_x_vec = '0;
    tick(); tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("reset");
    tick();

    run_pass(3, 32'b0, 1'b0);          // latency
    run_pass(3, 32'b100, 1'b0);        // bubble between vectors 1 and 2
    run_pass(0, 32'b0, 1'b0);          // zero count
    run_pass(4, 32'b0, 1'b1);          // start during STREAM is ignored

    // Reset in the middle of a stream drops everything in flight.
    start_pass(6);
    load_weights();
    drive_vector(32'hA1B2C3D4, 1'b1);
    tick();
    drive_vector(32'h55667788, 1'b1);
    tick();
    i_x_valid = 1'b0;
    rst = 1'b1;
    tick();
    flush_sb();
    check_idle_outputs("rst_hold");
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_release");
    tick();

    for (int r = 0; r < ROWS; r++) w_nz[r] = w_nz[r] ^ 4'b1010;
    w_nz[1] = 4'b0101;
    run_pass(5, 32'b10010, 1'b0);      // two bubbles

    check_eq("sb_empty", 64'(q_done.size() + q_pv[0].size() + q_pv[COLS-1].size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
